// File: rtl/load_store_unit.sv
// load_store_unit: sequences one CPU load/store onto a byte-addressed memory port with sign/zero extension and timeout.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses complete with err instead of reaching memory.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic        mem_request,
    output logic [2:0]  mem_bhw,
    output logic        mem_WR_nRD,
    output logic [31:0] mem_ADR,
    output logic [31:0] mem_DATA,
    input  logic [31:0] mem_DATAOUT,
    input  logic        mem_send
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    f3_q;
    logic          we_q;
    logic [2:0]    size;
    logic          bad_op;
    logic          misalign;
    logic [31:0]   ext;

    always_comb begin
        size = funct3[1:0] == 2'b00 ? 3'b001 :
               funct3[1:0] == 2'b01 ? 3'b010 :
               funct3[1:0] == 2'b10 ? 3'b100 : 3'b000;
        bad_op = we ? (funct3[2] | (&funct3[1:0])) : ((&funct3[1:0]) | (funct3[2] & funct3[1]));
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = (size[1] & addr[0]) | (size[2] & (|addr[1:0]));
`else
        misalign = 1'b0;
`endif
        // funct3[2] selects the unsigned variants, which suppress the sign fill
        ext = f3_q[1] ? mem_DATAOUT :
              f3_q[0] ? {{16{~f3_q[2] & mem_DATAOUT[15]}}, mem_DATAOUT[15:0]} :
                        {{24{~f3_q[2] & mem_DATAOUT[7]}}, mem_DATAOUT[7:0]};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            cnt         <= '0;
            f3_q        <= '0;
            we_q        <= 1'b0;
            rdata       <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
            mem_request <= 1'b0;
            mem_bhw     <= '0;
            mem_WR_nRD  <= 1'b0;
            mem_ADR     <= '0;
            mem_DATA    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    busy <= 1'b1;
                    we_q <= we;
                    f3_q <= funct3;
                    if (bad_op || misalign) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= RESP;
                    end else begin
                        mem_request <= 1'b1;
                        mem_bhw     <= size;
                        mem_WR_nRD  <= we;
                        mem_ADR     <= addr;
                        mem_DATA    <= wdata;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    mem_request <= 1'b0;
                    cnt         <= '0;
                    state       <= WAIT;
                end
                WAIT: if (mem_send) begin
                    if (!we_q) rdata <= ext;
                    done  <= 1'b1;
                    err   <= 1'b0;
                    state <= RESP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    done  <= 1'b1;
                    err   <= 1'b1;
                    state <= RESP;
                end else begin
                    cnt <= cnt == CW'(TIMEOUT) ? cnt : cnt + 1'b1;
                end
                RESP: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checks of load_store_unit against a transaction-level model.
module tb_load_store_unit;
    localparam int T = 16;
    localparam int NEVER = 1000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0, we = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, wdata = '0, mem_DATAOUT = '0;
    logic        mem_send = 1'b0;
    logic [31:0] rdata, mem_ADR, mem_DATA;
    logic        done, err, busy, mem_request, mem_WR_nRD;
    logic [2:0]  mem_bhw;

    load_store_unit #(.TIMEOUT(T)) dut (
        .CLK(CLK), .RST(RST), .start(start), .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
        .rdata(rdata), .done(done), .err(err), .busy(busy), .mem_request(mem_request),
        .mem_bhw(mem_bhw), .mem_WR_nRD(mem_WR_nRD), .mem_ADR(mem_ADR), .mem_DATA(mem_DATA),
        .mem_DATAOUT(mem_DATAOUT), .mem_send(mem_send)
    );

    always #5 CLK = ~CLK;

    int total = 0, bad = 0, cyc = 0;

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit op_ok(input bit w, input logic [2:0] f);
        return w ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    endfunction

    function automatic int nbytes(input logic [2:0] f);
        return 1 << f[1:0];
    endfunction

    function automatic bit misal(input logic [2:0] f, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return (a % nbytes(f)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f, input logic [31:0] d);
        case (f)
            3'd0:    return 32'($signed(d[7:0]));
            3'd1:    return 32'($signed(d[15:0]));
            3'd4:    return d & 32'hFF;
            3'd5:    return d & 32'hFFFF;
            default: return d;
        endcase
    endfunction

    // Model: tracks an access by edges elapsed since it was accepted.
    bit          m_act = 0, m_done = 0, m_err = 0, m_req = 0, m_we = 0, m_wr = 0, was_done = 0;
    int          m_age = 0;
    logic [2:0]  m_f3 = '0, m_bhw = '0;
    logic [31:0] m_rdata = '0, m_adr = '0, m_data = '0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_act = 0; m_done = 0; m_err = 0; m_req = 0; m_we = 0; m_wr = 0; m_age = 0;
            m_f3 = '0; m_bhw = '0; m_rdata = '0; m_adr = '0; m_data = '0;
        end else begin
            was_done = m_done;
            m_done = 0;
            m_req = 0;
            if (!m_act) begin
                if (start && !was_done) begin
                    m_we = we;
                    m_f3 = funct3;
                    if (!op_ok(we, funct3) || misal(funct3, addr)) begin
                        m_done = 1; m_err = 1;
                    end else begin
                        m_act = 1; m_age = 0; m_req = 1;
                        m_bhw = 3'(nbytes(funct3)); m_wr = we; m_adr = addr; m_data = wdata;
                    end
                end
            end else begin
                m_age++;
                if (m_age >= 2 && mem_send) begin
                    m_done = 1; m_err = 0; m_act = 0;
                    if (!m_we) m_rdata = load_val(m_f3, mem_DATAOUT);
                end else if (m_age == T + 1) begin
                    m_done = 1; m_err = 1; m_act = 0;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            chk("done", done, m_done);
            if (m_done) chk("err", err, m_err);
            chk("busy", busy, m_act || m_done);
            chk("mem_request", mem_request, m_req);
            chk("rdata", rdata, m_rdata);
            chk("mem_bhw", mem_bhw, m_bhw);
            chk("mem_WR_nRD", mem_WR_nRD, m_wr);
            chk("mem_ADR", mem_ADR, m_adr);
            chk("mem_DATA", mem_DATA, m_data);
        end
    end

    // Memory responder: answers a request after dly_cfg cycles; optional stray pulses while idle.
    int          dly_cfg = NEVER, cnt_r = -1, req_count = 0;
    bit          stray_en = 0;
    logic [2:0]  cap_bhw = '0;
    logic        cap_wr = 1'b0;
    logic [31:0] cap_adr = '0, cap_data = '0;

    always @(negedge CLK or posedge RST) begin
        if (RST) begin
            mem_send = 1'b0;
            cnt_r = -1;
        end else begin
            mem_send = 1'b0;
            if (cnt_r > 0) cnt_r--;
            if (cnt_r == 0) begin
                mem_send = 1'b1;
                cnt_r = -1;
            end
            if (done) cnt_r = -1;
            if (mem_request) begin
                cnt_r = dly_cfg;
                req_count++;
                cap_bhw = mem_bhw; cap_wr = mem_WR_nRD; cap_adr = mem_ADR; cap_data = mem_DATA;
            end
            if (stray_en && cnt_r < 0 && !busy && $urandom_range(0, 7) == 0) mem_send = 1'b1;
        end
    end

    task automatic op(input bit w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] mv, input int dl, input bit junk, output int lat, output logic e);
        int t0;
        @(negedge CLK);
        we = w; funct3 = f; addr = a; wdata = d; mem_DATAOUT = mv; dly_cfg = dl; start = 1'b1;
        t0 = cyc;
        lat = -1;
        e = 1'bx;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            start = 1'b0;
            if (done) begin
                lat = cyc - t0;
                e = err;
                break;
            end
            if (junk) begin
                start = 1'($urandom_range(0, 1));
                we = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
            end
        end
        start = 1'b0;
        if (lat < 0) begin
            total++;
            bad++;
            $display("FAIL op_wait no done within 60 cycles");
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_req"}, mem_request, 0);
        chk({tag, "_bhw"}, mem_bhw, 0);
        chk({tag, "_wr"}, mem_WR_nRD, 0);
        chk({tag, "_adr"}, mem_ADR, 0);
        chk({tag, "_data"}, mem_DATA, 0);
    endtask

    initial begin
        int lat, r, n0;
        logic e;
        logic [2:0] f;
        logic [31:0] mv;
        #1 check_reset("reset");
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        op(0, 3'd0, 32'h10, 0, 32'hF0, 1, 0, lat, e);
        chk("lb_rdata", rdata, 32'hFFFFFFF0);
        chk("lb_lat", lat, 3);
        chk("lb_bhw", cap_bhw, 3'b001);
        op(0, 3'd4, 32'h10, 0, 32'hF0, 1, 0, lat, e);
        chk("lbu_rdata", rdata, 32'h000000F0);
        chk("lbu_bhw", cap_bhw, 3'b001);

        op(1, 3'd2, 32'h20, 32'hDEADBEEF, 32'h12345678, 2, 0, lat, e);
        chk("sw_bhw", cap_bhw, 3'b100);
        chk("sw_wr", cap_wr, 1);
        chk("sw_data", cap_data, 32'hDEADBEEF);
        chk("sw_adr", cap_adr, 32'h20);
        chk("sw_err", e, 0);
        chk("sw_lat", lat, 4);
        chk("sw_rdata_hold", rdata, 32'h000000F0);

        op(0, 3'd1, 32'h40, 0, 32'h00008001, 5, 1, lat, e);
        chk("lh_rdata", rdata, 32'hFFFF8001);
        chk("lh_lat", lat, 7);

        op(0, 3'd2, 32'h30, 0, 32'h0000AAAA, NEVER, 0, lat, e);
        chk("to_lat", lat, T + 2);
        chk("to_err", e, 1);
        chk("to_rdata_hold", rdata, 32'hFFFF8001);

        op(0, 3'd2, 32'h34, 0, 32'h0BADF00D, T, 0, lat, e);
        chk("edge_send_err", e, 0);
        chk("edge_send_rdata", rdata, 32'h0BADF00D);

        n0 = req_count;
        op(0, 3'd3, 32'h50, 0, 32'h1, 1, 0, lat, e);
        chk("bad_lat", lat, 1);
        chk("bad_err", e, 1);
        chk("bad_noreq", req_count, n0);

        n0 = req_count;
`ifdef LSU_MISALIGN_TRAP_EN
        op(0, 3'd2, 32'h22, 0, 32'h11223344, 1, 0, lat, e);
        chk("mis_lat", lat, 1);
        chk("mis_err", e, 1);
        chk("mis_noreq", req_count, n0);
`else
        op(0, 3'd2, 32'h22, 0, 32'h11223344, 3, 0, lat, e);
        chk("mis_adr", cap_adr, 32'h22);
        chk("mis_lat", lat, 5);
        chk("mis_req", req_count, n0 + 1);
`endif

        @(negedge CLK);
        we = 0; funct3 = 3'd2; addr = 32'h44; mem_DATAOUT = 32'h55; dly_cfg = NEVER; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (4) @(negedge CLK);
        #2 RST = 1'b1;
        #1 check_reset("midrst");
        @(negedge CLK);
        RST = 1'b0;

        stray_en = 1;
        for (int i = 0; i < 200; i++) begin
            f = 3'($urandom_range(0, 7));
            mv = $urandom;
            if (f[1:0] == 2'd0) mv &= 32'hFF;
            else if (f[1:0] == 2'd1) mv &= 32'hFFFF;
            r = $urandom_range(0, 9);
            op(1'($urandom_range(0, 1)), f, $urandom, $urandom, mv,
               r < 7 ? $urandom_range(1, 4) : r == 7 ? T : r == 8 ? T + 1 : NEVER,
               1'($urandom_range(0, 1)), lat, e);
        end
        stray_en = 0;
        repeat (3) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
